// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm controller slice.
// Imported by the counter primitive and the alarm_ctrl top.
package alarm_pkg;

   typedef enum logic [1:0] {
      ALM_IDLE   = 2'd0,
      ALM_RING   = 2'd1,
      ALM_SNOOZE = 2'd2
   } alm_state_t;

   localparam int HR_MOD  = 24;
   localparam int MIN_MOD = 60;

   // Width of the time fields as carried on the counter-chain buses.
   localparam int TIME_W = 7;

   // Width of the ring and snooze minute counters.
   localparam int MCT_W = 6;

endpackage

// File: rtl/ct_mod_N.sv
// Enabled modulo-N up counter with synchronous reset.
// z_o flags the wrap from N-1 back to zero in the enabled cycle.
module ct_mod_N #(
   parameter int N = 60,
   parameter int W = 7
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en_i,
   output logic [W-1:0] ct_o,
   output logic         z_o
);

   logic [W-1:0] ct_q;
   logic [W-1:0] ct_d;
   logic         at_top;

   assign at_top = (ct_q == W'(N - 1));

   always_comb begin
      ct_d = ct_q;
      if (en_i) begin
         if (at_top) begin
            ct_d = '0;
         end else begin
            ct_d = ct_q + W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ct_q <= '0;
      end else begin
         ct_q <= ct_d;
      end
   end

   assign ct_o = ct_q;
   assign z_o  = en_i & at_top;

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm controller: settable alarm time plus ring/snooze/timeout state machine
// driven by the once-per-minute tick from the time-of-day chain.
module alarm_ctrl
   import alarm_pkg::*;
#(
   parameter int SNOOZE_MIN   = 9,
   parameter int RING_MAX_MIN = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              min_tick,
   input  logic [TIME_W-1:0] cur_hr,
   input  logic [TIME_W-1:0] cur_min,
   input  logic              alarm_en,
   input  logic              set_mode,
   input  logic              inc_hr,
   input  logic              inc_min,
   input  logic              snooze,
   input  logic              stop,
   output logic [TIME_W-1:0] alm_hr,
   output logic [TIME_W-1:0] alm_min,
   output logic              buzz,
   output logic              snoozing,
   output logic [1:0]        state
);

   localparam logic [MCT_W-1:0] SNZ_LOAD  = MCT_W'(SNOOZE_MIN);
   localparam logic [MCT_W-1:0] RING_LAST = MCT_W'(RING_MAX_MIN - 1);

   logic [TIME_W-1:0] alm_hr_ct;
   logic [TIME_W-1:0] alm_min_ct;
   logic              hr_wrap_unused;
   logic              min_wrap_unused;

   alm_state_t        state_q;
   alm_state_t        state_d;
   logic [MCT_W-1:0]  ring_ct_q;
   logic [MCT_W-1:0]  ring_ct_d;
   logic [MCT_W-1:0]  snz_ct_q;
   logic [MCT_W-1:0]  snz_ct_d;
   logic              buzz_q;
   logic              snoozing_q;

   logic              match;
   logic              abort;

   // Alarm-time fields: minutes never carry into the hour.
   ct_mod_N #(
      .N (MIN_MOD),
      .W (TIME_W)
   ) u_alm_min (
      .clk  (clk),
      .rst  (rst),
      .en_i (set_mode & inc_min),
      .ct_o (alm_min_ct),
      .z_o  (min_wrap_unused)
   );

   ct_mod_N #(
      .N (HR_MOD),
      .W (TIME_W)
   ) u_alm_hr (
      .clk  (clk),
      .rst  (rst),
      .en_i (set_mode & inc_hr),
      .ct_o (alm_hr_ct),
      .z_o  (hr_wrap_unused)
   );

   assign match = min_tick && (cur_hr == alm_hr_ct) && (cur_min == alm_min_ct);
   assign abort = stop || !alarm_en || set_mode;

   always_comb begin
      state_d   = state_q;
      ring_ct_d = ring_ct_q;
      snz_ct_d  = snz_ct_q;

      case (state_q)
         ALM_IDLE: begin
            if (match && alarm_en && !set_mode) begin
               state_d   = ALM_RING;
               ring_ct_d = '0;
               snz_ct_d  = '0;
            end
         end

         ALM_RING: begin
            if (abort) begin
               state_d   = ALM_IDLE;
               ring_ct_d = '0;
               snz_ct_d  = '0;
            end else if (snooze) begin
               state_d  = ALM_SNOOZE;
               snz_ct_d = SNZ_LOAD;
            end else if (min_tick) begin
               if (ring_ct_q == RING_LAST) begin
                  state_d   = ALM_IDLE;
                  ring_ct_d = '0;
                  snz_ct_d  = '0;
               end else begin
                  ring_ct_d = ring_ct_q + MCT_W'(1);
               end
            end
         end

         // Further snooze pulses are deliberately not decoded here.
         ALM_SNOOZE: begin
            if (abort) begin
               state_d   = ALM_IDLE;
               ring_ct_d = '0;
               snz_ct_d  = '0;
            end else if (min_tick) begin
               if (snz_ct_q == MCT_W'(1)) begin
                  state_d   = ALM_RING;
                  ring_ct_d = '0;
                  snz_ct_d  = '0;
               end else begin
                  snz_ct_d = snz_ct_q - MCT_W'(1);
               end
            end
         end

         default: begin
            state_d   = ALM_IDLE;
            ring_ct_d = '0;
            snz_ct_d  = '0;
         end
      endcase
   end

   // Output flags are decoded from the next state so they align with state_q.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ALM_IDLE;
         ring_ct_q  <= '0;
         snz_ct_q   <= '0;
         buzz_q     <= 1'b0;
         snoozing_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         ring_ct_q  <= ring_ct_d;
         snz_ct_q   <= snz_ct_d;
         buzz_q     <= (state_d == ALM_RING);
         snoozing_q <= (state_d == ALM_SNOOZE);
      end
   end

   assign alm_hr   = alm_hr_ct;
   assign alm_min  = alm_min_ct;
   assign buzz     = buzz_q;
   assign snoozing = snoozing_q;
   assign state    = state_q;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Directed bench for alarm_ctrl: table of alarm-set vectors followed by
// hand-written ring, snooze, timeout, conflict and reset sequences.
module tb_alarm_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       min_tick;
   logic [6:0] cur_hr;
   logic [6:0] cur_min;
   logic       alarm_en;
   logic       set_mode;
   logic       inc_hr;
   logic       inc_min;
   logic       snooze;
   logic       stop;
   logic [6:0] alm_hr;
   logic [6:0] alm_min;
   logic       buzz;
   logic       snoozing;
   logic [1:0] state;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   alarm_ctrl #(
      .SNOOZE_MIN   (9),
      .RING_MAX_MIN (5)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .min_tick (min_tick),
      .cur_hr   (cur_hr),
      .cur_min  (cur_min),
      .alarm_en (alarm_en),
      .set_mode (set_mode),
      .inc_hr   (inc_hr),
      .inc_min  (inc_min),
      .snooze   (snooze),
      .stop     (stop),
      .alm_hr   (alm_hr),
      .alm_min  (alm_min),
      .buzz     (buzz),
      .snoozing (snoozing),
      .state    (state)
   );

   typedef struct {
      logic sm;
      logic ih;
      logic im;
      int   reps;
      int   exp_hr;
      int   exp_min;
   } set_vec_t;

   set_vec_t vecs [9];

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end else begin
         $display("ok   %s = %0d", name, act);
      end
   endtask

   // Advance one clock; outputs are sampled 1 time unit after the edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic mtick(input int hr, input int mn);
      cur_hr   = 7'(hr);
      cur_min  = 7'(mn);
      min_tick = 1'b1;
      cyc();
      min_tick = 1'b0;
   endtask

   task automatic pulse_stop();
      stop = 1'b1;
      cyc();
      stop = 1'b0;
   endtask

   task automatic pulse_snooze();
      snooze = 1'b1;
      cyc();
      snooze = 1'b0;
   endtask

   initial begin
      vecs[0] = '{sm: 1'b1, ih: 1'b1, im: 1'b0, reps: 7,  exp_hr: 7, exp_min: 0};
      vecs[1] = '{sm: 1'b1, ih: 1'b0, im: 1'b1, reps: 61, exp_hr: 7, exp_min: 1};
      vecs[2] = '{sm: 1'b0, ih: 1'b1, im: 1'b0, reps: 1,  exp_hr: 7, exp_min: 1};
      vecs[3] = '{sm: 1'b0, ih: 1'b0, im: 1'b1, reps: 1,  exp_hr: 7, exp_min: 1};
      vecs[4] = '{sm: 1'b1, ih: 1'b1, im: 1'b1, reps: 1,  exp_hr: 8, exp_min: 2};
      vecs[5] = '{sm: 1'b1, ih: 1'b1, im: 1'b0, reps: 16, exp_hr: 0, exp_min: 2};
      vecs[6] = '{sm: 1'b1, ih: 1'b0, im: 1'b1, reps: 58, exp_hr: 0, exp_min: 0};
      vecs[7] = '{sm: 1'b1, ih: 1'b1, im: 1'b0, reps: 7,  exp_hr: 7, exp_min: 0};
      vecs[8] = '{sm: 1'b1, ih: 1'b0, im: 1'b1, reps: 30, exp_hr: 7, exp_min: 30};

      rst      = 1'b1;
      min_tick = 1'b0;
      cur_hr   = 7'd0;
      cur_min  = 7'd0;
      alarm_en = 1'b0;
      set_mode = 1'b0;
      inc_hr   = 1'b0;
      inc_min  = 1'b0;
      snooze   = 1'b0;
      stop     = 1'b0;
      cyc();
      cyc();
      rst = 1'b0;

      check("reset state", int'(state), 0);
      check("reset buzz", int'(buzz), 0);
      check("reset snoozing", int'(snoozing), 0);
      check("reset alm_hr", int'(alm_hr), 0);
      check("reset alm_min", int'(alm_min), 0);

      for (int v = 0; v < 9; v++) begin
         set_mode = vecs[v].sm;
         for (int r = 0; r < vecs[v].reps; r++) begin
            inc_hr  = vecs[v].ih;
            inc_min = vecs[v].im;
            cyc();
         end
         inc_hr   = 1'b0;
         inc_min  = 1'b0;
         set_mode = 1'b0;
         check($sformatf("vec%0d alm_hr", v), int'(alm_hr), vecs[v].exp_hr);
         check($sformatf("vec%0d alm_min", v), int'(alm_min), vecs[v].exp_min);
      end

      // Basic ring and stop at 07:30.
      alarm_en = 1'b1;
      mtick(7, 29);
      check("no match buzz", int'(buzz), 0);
      mtick(7, 30);
      check("ring buzz", int'(buzz), 1);
      check("ring state", int'(state), 1);
      pulse_stop();
      check("stop buzz", int'(buzz), 0);
      check("stop state", int'(state), 0);

      // Disarmed match.
      alarm_en = 1'b0;
      mtick(7, 30);
      check("disarmed state", int'(state), 0);
      check("disarmed buzz", int'(buzz), 0);
      alarm_en = 1'b1;

      // Snooze for 9 minutes then re-ring.
      mtick(7, 30);
      pulse_snooze();
      check("snooze snoozing", int'(snoozing), 1);
      check("snooze buzz", int'(buzz), 0);
      check("snooze state", int'(state), 2);
      for (int i = 0; i < 8; i++) mtick(7, 31 + i);
      check("snooze 8 ticks state", int'(state), 2);
      check("snooze 8 ticks buzz", int'(buzz), 0);
      mtick(7, 39);
      check("snooze expiry buzz", int'(buzz), 1);
      check("snooze expiry state", int'(state), 1);

      // Timeout from the re-entered RING.
      for (int i = 0; i < 4; i++) mtick(7, 40 + i);
      check("timeout 4 ticks buzz", int'(buzz), 1);
      mtick(7, 44);
      check("timeout buzz", int'(buzz), 0);
      check("timeout state", int'(state), 0);

      // Stop and snooze together.
      mtick(7, 30);
      stop   = 1'b1;
      snooze = 1'b1;
      cyc();
      stop   = 1'b0;
      snooze = 1'b0;
      check("stop+snooze state", int'(state), 0);
      check("stop+snooze snoozing", int'(snoozing), 0);

      // Disarm during snooze.
      mtick(7, 30);
      pulse_snooze();
      alarm_en = 1'b0;
      cyc();
      alarm_en = 1'b1;
      check("disarm in snooze state", int'(state), 0);
      check("disarm in snooze snoozing", int'(snoozing), 0);

      // A repeated match while ringing does not restart the timeout.
      mtick(7, 30);
      mtick(7, 31);
      mtick(7, 32);
      mtick(7, 30);
      mtick(7, 33);
      check("rematch still ringing", int'(state), 1);
      mtick(7, 34);
      check("rematch timeout state", int'(state), 0);
      check("rematch timeout buzz", int'(buzz), 0);

      // Reset mid-ring.
      mtick(7, 30);
      check("pre-reset state", int'(state), 1);
      rst = 1'b1;
      stop = 1'b0;
      cyc();
      rst = 1'b0;
      check("rst state", int'(state), 0);
      check("rst buzz", int'(buzz), 0);
      check("rst snoozing", int'(snoozing), 0);
      check("rst alm_hr", int'(alm_hr), 0);
      check("rst alm_min", int'(alm_min), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/alarm_ctrl.md
# alarm_ctrl

Alarm controller for the building alarm clock, directly downstream of the time-of-day counter chain. It consumes the current hour/minute counts and a once-per-minute tick, and holds a user-settable alarm time. When the time matches and the alarm is armed, it drives the buzzer through a ring / snooze state machine with minute-granular snooze and auto-timeout.

## Interface
Parameters:
- SNOOZE_MIN, 9: minutes spent in snooze before re-ringing; legal range 1..63.
- RING_MAX_MIN, 5: minutes of continuous ringing before auto-stop; legal range 1..63.

Ports (clock is clk; reset is rst, synchronous, active-high):
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- min_tick  in  1  one-cycle pulse marking a new minute; cur_hr/cur_min already hold the new value in this cycle
- cur_hr  in  7  current hour, 0..23
- cur_min  in  7  current minute, 0..59
- alarm_en  in  1  arm switch (level)
- set_mode  in  1  alarm-set mode (level)
- inc_hr  in  1  debounced one-cycle pulse, increments the alarm hour
- inc_min  in  1  debounced one-cycle pulse, increments the alarm minute
- snooze  in  1  one-cycle pulse
- stop  in  1  one-cycle pulse
- alm_hr  out  7  alarm hour, 0..23
- alm_min  out  7  alarm minute, 0..59
- buzz  out  1  buzzer drive
- snoozing  out  1  high while in SNOOZE
- state  out  2  FSM state encoding, for debug and display

## Operation
Alarm time:
- Only in set_mode: inc_min sets alm_min to (alm_min+1) mod 60, with no carry into the hour.
- Only in set_mode: inc_hr sets alm_hr to (alm_hr+1) mod 24.
- Both pulses in the same cycle: both fields increment.
- Outside set_mode, inc_hr and inc_min are ignored.

Match:
- match = min_tick && cur_hr==alm_hr && cur_min==alm_min.
- Match is sampled only on min_tick cycles.

Counters:
- ring_ct and snz_ct are 6 bits each.
- Both are cleared on every entry to RING or IDLE.

FSM states: IDLE=0, RING=1, SNOOZE=2. Encoding 3 is unreachable; if it occurs, the next state is IDLE.

IDLE transitions:
- match && alarm_en && !set_mode goes to RING.

RING transitions, highest priority first:
1. stop, or !alarm_en, or set_mode: go to IDLE.
2. snooze: go to SNOOZE and load snz_ct=SNOOZE_MIN.
3. min_tick && ring_ct==RING_MAX_MIN-1: go to IDLE (timeout).
4. min_tick otherwise: increment ring_ct.

SNOOZE transitions:
1. stop, or !alarm_en, or set_mode: go to IDLE.
2. min_tick && snz_ct==1: go to RING.
3. min_tick otherwise: decrement snz_ct.
4. A snooze pulse in SNOOZE is ignored.

Other rules:
- A match while in RING or SNOOZE is ignored; there is no re-trigger or extension.
- buzz is high in RING and low otherwise.
- snoozing is high in SNOOZE.
- Assumption: cur_hr and cur_min are in range. Out-of-range values simply never match.

## Timing
- Reset values: state=IDLE, buzz=0, snoozing=0, alm_hr=0, alm_min=0, ring_ct=0, snz_ct=0.
- All outputs are registered; there are no combinational input-to-output paths.
- Alarm-time update: alm_hr/alm_min change on the clock edge that samples the inc pulse, so they are visible the next cycle.
- Ring latency: buzz rises one cycle after the matching min_tick cycle.
- The min_tick that triggers the IDLE→RING transition does not count toward ring_ct.
- Timeout: the alarm rings across exactly RING_MAX_MIN subsequent min_ticks. buzz falls one cycle after the last of them.
- Snooze: exactly SNOOZE_MIN min_ticks are spent in SNOOZE. buzz rises one cycle after the last of them.
- Reset mid-ring wins over every input. The alarm time returns to 00:00.

## Structure
- Package alarm_pkg holds:
  - alm_state_t enum: ALM_IDLE, ALM_RING, ALM_SNOOZE (2 bits).
  - HR_MOD=24 and MIN_MOD=60.
- Alarm-time registers are two instances of the existing ct_mod_N:
  - minutes: N=MIN_MOD, en=set_mode&inc_min.
  - hours: N=HR_MOD, en=set_mode&inc_hr.
  - Their z outputs are unused.
- FSM and the ring/snooze counters live in alarm_ctrl itself; no further sub-modules.

## Test plan
- Set alarm: set_mode=1, then 7 inc_hr pulses and 61 inc_min pulses → alm_hr=7, alm_min=1.
- Set mode off: inc_hr pulse with set_mode=0 → alm_hr unchanged.
- Basic ring: alarm 07:30 and armed; min_tick with cur=07:30 → buzz=1 the next cycle and state=RING. A stop pulse → buzz=0 the next cycle and state=IDLE.
- Disarmed: same match with alarm_en=0 → state stays IDLE and buzz=0.
- Snooze (SNOOZE_MIN=9): while ringing, pulse snooze → snoozing=1 and buzz=0. After 8 min_ticks state is still SNOOZE; one cycle after the 9th, buzz=1.
- Timeout (RING_MAX_MIN=5): ring, then 5 min_ticks → buzz=0 one cycle after the 5th.
- Conflicts and mid-operation events:
  - stop and snooze in the same cycle → IDLE.
  - alarm_en dropped during SNOOZE → IDLE.
  - A second match at 07:30 while in RING (e.g. after a day-length wrap in the bench) → ring_ct is not reset.
- Reset mid-operation: rst during RING → all outputs return to reset values the next cycle.
